// File: rtl/t07_mc_control_fsm.sv
// Multi-cycle RV32I/F control FSM: latches instr into IR, steps FETCH/DECODE/EXEC/MEM/FPUW/WB, Moore outputs only.
// Latency 4 cycles + fetch/mem/FPU wait; stalls on mem_ack/fpu_done, traps on wait timeout or illegal encoding.
module t07_mc_control_fsm #(
    parameter int unsigned EN_FPU    = 1,
    parameter int unsigned TIMEOUT_W = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        mem_ack,
    input  logic        fpu_done,
    input  logic        trap_clr,
    output logic        fetch_req,
    output logic        pc_en,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        branch,
    output logic        jump,
    output logic        memRead,
    output logic        memWrite,
    output logic [3:0]  memOp,
    output logic        memSrc,
    output logic [2:0]  regWriteSrc,
    output logic        regWrite,
    output logic        FPUWrite,
    output logic        fpu_start,
    output logic [4:0]  FPUOp,
    output logic [2:0]  FPURnd,
    output logic [4:0]  rs3,
    output logic        invalid_Op,
    output logic        timeout_err,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
        ST_FPUW  = 3'd4, ST_WB     = 3'd5, ST_TRAP = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;
    localparam logic FPU_ON = (EN_FPU != 0);

    state_t                state_q, state_d;
    logic [31:0]           ir_q, ir_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs2;
    logic       alt;
    logic       dec_ok, dec_mem, dec_fp, dec_alu_src, dec_branch, dec_jump;
    logic       dec_mem_rd, dec_mem_wr, dec_mem_src, dec_reg_wr, dec_fpu_wr;
    logic [3:0] dec_alu_op, dec_mem_op, alu_map;
    logic [2:0] dec_wsrc, dec_fpu_rnd;
    logic [4:0] dec_fpu_op;
    logic       unused_ir;

    assign opc = ir_q[6:0];
    assign f3  = ir_q[14:12];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];
    assign unused_ir = ^{ir_q[19:15], ir_q[11:7]};
    // funct7[5] selects sub/sra; for OP-IMM funct3=0 it is immediate data, not an alternate op
    assign alt = f7[5] && ((opc == 7'b0110011) || (f3 == 3'd5));

    always_comb begin
        case (f3)
            3'd0:    alu_map = alt ? 4'd8 : 4'd0;
            3'd1:    alu_map = 4'd3;
            3'd2:    alu_map = 4'd4;
            3'd3:    alu_map = 4'd5;
            3'd4:    alu_map = 4'd9;
            3'd5:    alu_map = alt ? 4'd6 : 4'd7;
            3'd6:    alu_map = 4'd2;
            default: alu_map = 4'd1;
        endcase
    end

    always_comb begin
        dec_ok = 1'b0;  dec_mem = 1'b0;  dec_fp = 1'b0;
        dec_alu_op = 4'd10;  dec_alu_src = 1'b0;  dec_branch = 1'b0;  dec_jump = 1'b0;
        dec_mem_rd = 1'b0;  dec_mem_wr = 1'b0;  dec_mem_op = 4'd0;  dec_mem_src = 1'b0;
        dec_wsrc = 3'b000;  dec_reg_wr = 1'b0;  dec_fpu_wr = 1'b0;
        dec_fpu_op = 5'd0;  dec_fpu_rnd = 3'd0;
        case (opc)
            7'b0110111: begin dec_ok = 1'b1; dec_reg_wr = 1'b1; dec_wsrc = 3'b100; end
            7'b0010111: begin
                dec_ok = 1'b1; dec_alu_op = 4'd0; dec_alu_src = 1'b1;
                dec_reg_wr = 1'b1; dec_wsrc = 3'b010;
            end
            7'b1101111: begin dec_ok = 1'b1; dec_jump = 1'b1; dec_reg_wr = 1'b1; end
            7'b1100111: begin
                dec_ok = (f3 == 3'd0); dec_jump = 1'b1; dec_alu_op = 4'd0;
                dec_alu_src = 1'b1; dec_reg_wr = 1'b1;
            end
            7'b1100011: begin
                dec_ok = (f3 != 3'd2) && (f3 != 3'd3); dec_branch = 1'b1;
                dec_alu_op = f3[2] ? (f3[1] ? 4'd5 : 4'd4) : 4'd8;
            end
            7'b0000011: begin
                dec_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
                dec_mem = 1'b1; dec_mem_rd = 1'b1; dec_alu_op = 4'd0; dec_alu_src = 1'b1;
                dec_mem_op = f3[2] ? {1'b0, f3} : {1'b0, f3} + 4'd1;
                dec_reg_wr = 1'b1; dec_wsrc = 3'b001;
            end
            7'b0100011: begin
                dec_ok = (f3 <= 3'd2); dec_mem = 1'b1; dec_mem_wr = 1'b1;
                dec_alu_op = 4'd0; dec_alu_src = 1'b1; dec_mem_op = 4'd6 + {1'b0, f3};
            end
            7'b0010011: begin
                dec_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                         (f3 == 3'd5) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;
                dec_alu_op = alu_map; dec_alu_src = 1'b1; dec_reg_wr = 1'b1; dec_wsrc = 3'b010;
            end
            7'b0110011: begin
                dec_ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                dec_alu_op = alu_map; dec_reg_wr = 1'b1; dec_wsrc = 3'b010;
            end
            7'b0000111: begin
                dec_ok = FPU_ON && (f3 == 3'd2); dec_mem = 1'b1; dec_mem_rd = 1'b1;
                dec_mem_op = 4'd3; dec_mem_src = 1'b1; dec_alu_op = 4'd0; dec_alu_src = 1'b1;
                dec_fpu_wr = 1'b1; dec_wsrc = 3'b001; dec_fpu_op = 5'd1;
            end
            7'b0100111: begin
                dec_ok = FPU_ON && (f3 == 3'd2); dec_mem = 1'b1; dec_mem_wr = 1'b1;
                dec_mem_op = 4'd8; dec_mem_src = 1'b1; dec_alu_op = 4'd0; dec_alu_src = 1'b1;
                dec_fpu_op = 5'd2;
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                dec_ok = FPU_ON && (f7[1:0] == 2'b00); dec_fp = 1'b1; dec_fpu_wr = 1'b1;
                dec_wsrc = 3'b011; dec_fpu_op = 5'd3 + {3'b000, opc[3:2]};
            end
            7'b1010011: begin
                dec_fp = 1'b1; dec_wsrc = 3'b011; dec_fpu_wr = 1'b1;
                case (f7)
                    7'h00: begin dec_ok = FPU_ON; dec_fpu_op = 5'd7;  end
                    7'h04: begin dec_ok = FPU_ON; dec_fpu_op = 5'd8;  end
                    7'h08: begin dec_ok = FPU_ON; dec_fpu_op = 5'd9;  end
                    7'h0C: begin dec_ok = FPU_ON; dec_fpu_op = 5'd10; end
                    7'h2C: begin dec_ok = FPU_ON && (rs2 == 5'd0); dec_fpu_op = 5'd11; end
                    7'h10: begin
                        dec_ok = FPU_ON && (f3 <= 3'd2); dec_fpu_op = 5'd12 + {2'b00, f3};
                        dec_fpu_rnd = f3;
                    end
                    7'h14: begin
                        dec_ok = FPU_ON && (f3 <= 3'd1); dec_fpu_op = 5'd15 + {2'b00, f3};
                        dec_fpu_rnd = f3;
                    end
                    7'h60: begin
                        dec_ok = FPU_ON && (rs2[4:1] == 4'd0); dec_fpu_op = 5'd17 + {4'd0, rs2[0]};
                        dec_fpu_wr = 1'b0; dec_reg_wr = 1'b1;
                    end
                    7'h70: begin
                        dec_ok = FPU_ON && (f3 <= 3'd1) && (rs2 == 5'd0);
                        dec_fpu_op = f3[0] ? 5'd23 : 5'd19; dec_fpu_rnd = f3;
                        dec_fpu_wr = 1'b0; dec_reg_wr = 1'b1;
                    end
                    7'h50: begin
                        dec_ok = FPU_ON && (f3 <= 3'd2); dec_fpu_op = 5'd22 - {2'b00, f3};
                        dec_fpu_rnd = f3; dec_fpu_wr = 1'b0; dec_reg_wr = 1'b1;
                    end
                    7'h68: begin dec_ok = FPU_ON && (rs2[4:1] == 4'd0); dec_fpu_op = 5'd24 + {4'd0, rs2[0]}; end
                    7'h78: begin dec_ok = FPU_ON && (f3 == 3'd0) && (rs2 == 5'd0); dec_fpu_op = 5'd26; end
                    default: dec_ok = 1'b0;
                endcase
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        cnt_d         = '0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_FETCH: if (instr_valid) begin ir_d = instr; state_d = ST_DECODE; end
            ST_DECODE: state_d = dec_ok ? ST_EXEC : ST_TRAP;
            ST_EXEC:   state_d = dec_mem ? ST_MEM : (dec_fp ? ST_FPUW : ST_WB);
            ST_MEM, ST_FPUW: begin
                // completion beats timeout when both land on the same cycle
                if ((state_q == ST_MEM) ? mem_ack : fpu_done) begin
                    state_d = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_TRAP; timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: if (trap_clr) begin state_d = ST_FETCH; timeout_err_d = 1'b0; end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_FETCH;
            ir_q          <= NOP_INSTR;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        logic in_ex, in_wb, in_mem, in_fp;
        in_ex  = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_FPUW) || (state_q == ST_WB);
        in_wb  = (state_q == ST_WB);
        in_mem = (state_q == ST_MEM);
        in_fp  = ((state_q == ST_EXEC) || (state_q == ST_FPUW)) && dec_fp;
        fetch_req   = (state_q == ST_FETCH);
        pc_en       = in_wb;
        ALUOp       = in_ex ? dec_alu_op : 4'd10;
        ALUSrc      = in_ex && dec_alu_src;
        branch      = in_wb && dec_branch;
        jump        = in_wb && dec_jump;
        memRead     = in_mem && dec_mem_rd;
        memWrite    = in_mem && dec_mem_wr;
        memOp       = in_mem ? dec_mem_op : 4'd0;
        memSrc      = (in_mem || in_wb) && dec_mem_src;
        regWriteSrc = in_wb ? dec_wsrc : 3'b000;
        regWrite    = in_wb && dec_reg_wr;
        FPUWrite    = in_wb && dec_fpu_wr;
        fpu_start   = (state_q == ST_EXEC) && dec_fp;
        FPUOp       = in_fp ? dec_fpu_op : 5'd0;
        FPURnd      = in_fp ? dec_fpu_rnd : 3'd0;
        rs3         = in_fp ? ir_q[31:27] : 5'd0;
        invalid_Op  = (state_q == ST_TRAP) && !timeout_err_q;
        timeout_err = timeout_err_q;
        state       = state_q;
    end
endmodule
